// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter
//   Sole owner of the byte-wide program memory port. It arbitrates between three
//   clients and drives a synchronous byte RAM with one cycle of read latency:
//     - UART loader: single byte writes, LD_REQ/LD_ACK handshake
//     - instruction fetch: 32-bit little-endian word built from four byte reads,
//       IF_REQ/IF_ACK handshake, misaligned or out-of-range addresses rejected
//     - memory clear: writes 0 to every byte, one byte per cycle
//
// Ports
//   CLK, RESET             clock and synchronous active-high reset
//   CLR_REQ / CLR_BUSY     clear request (level) / high for each clear write
//   LD_REQ, LD_ADDR,
//   LD_DATA / LD_ACK       loader write request / one-cycle write-done pulse
//   IF_REQ, IF_ADDR /
//   IF_ACK, IF_DATA,
//   IF_FAULT               fetch request / one-cycle done pulse, word, reject flag
//   MEM_ADDR, MEM_WE,
//   MEM_WDATA / MEM_RDATA  RAM port (read data valid one cycle after address)

module prog_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CLR_REQ,
    output logic              CLR_BUSY,
    input  logic              LD_REQ,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [7:0]        LD_DATA,
    output logic              LD_ACK,
    input  logic              IF_REQ,
    input  logic [31:0]       IF_ADDR,
    output logic              IF_ACK,
    output logic [31:0]       IF_DATA,
    output logic              IF_FAULT,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [7:0]        MEM_WDATA,
    input  logic [7:0]        MEM_RDATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_FETCH,
        S_FWAIT,
        S_FDONE,
        S_FAULT
    } state_t;

    localparam logic GRANT_LD = 1'b0;
    localparam logic GRANT_IF = 1'b1;

    // Highest legal word base; the compare is done on the full 32-bit PC so a
    // huge address can never alias into the RAM by truncation.
    localparam logic [31:0]       FETCH_LIMIT = 32'(DEPTH - 4);
    localparam logic [ADDR_W-1:0] CLR_LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

    state_t              state_q;
    logic [1:0]          k_q;
    logic                last_grant_q;
    logic                clr_busy_q;
    logic                ld_ack_q;
    logic                if_ack_q;
    logic                if_fault_q;
    logic [31:0]         if_data_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_we_q;
    logic [7:0]          mem_wdata_q;
    // Bytes 0..2 are collected here so IF_DATA only changes on IF_ACK.
    logic [23:0]         byte_buf_q;

    logic                fetch_bad_d;
    logic                grant_ld_d;
    logic                grant_if_d;

    always_comb begin
        fetch_bad_d = (IF_ADDR[1:0] != 2'b00) || (IF_ADDR > FETCH_LIMIT);
        // On a tie, serve whoever was not served last.
        grant_ld_d  = LD_REQ && (!IF_REQ || (last_grant_q == GRANT_IF));
        grant_if_d  = IF_REQ && !grant_ld_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            k_q          <= 2'd0;
            last_grant_q <= GRANT_IF;
            clr_busy_q   <= 1'b0;
            ld_ack_q     <= 1'b0;
            if_ack_q     <= 1'b0;
            if_fault_q   <= 1'b0;
            if_data_q    <= 32'd0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (CLR_REQ) begin
                        state_q     <= S_CLEAR;
                        clr_busy_q  <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= 8'd0;
                    end else if (grant_ld_d) begin
                        state_q      <= S_LOAD;
                        last_grant_q <= GRANT_LD;
                        ld_ack_q     <= 1'b1;
                        mem_we_q     <= 1'b1;
                        mem_addr_q   <= LD_ADDR;
                        mem_wdata_q  <= LD_DATA;
                    end else if (grant_if_d) begin
                        last_grant_q <= GRANT_IF;
                        if (fetch_bad_d) begin
                            state_q    <= S_FAULT;
                            if_ack_q   <= 1'b1;
                            if_fault_q <= 1'b1;
                            if_data_q  <= 32'd0;
                        end else begin
                            state_q    <= S_FETCH;
                            k_q        <= 2'd0;
                            mem_addr_q <= IF_ADDR[ADDR_W-1:0];
                        end
                    end
                end

                S_CLEAR: begin
                    if (mem_addr_q == CLR_LAST) begin
                        state_q    <= S_IDLE;
                        clr_busy_q <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= '0;
                    end else begin
                        mem_addr_q <= mem_addr_q + ADDR_ONE;
                    end
                end

                S_LOAD: begin
                    state_q     <= S_IDLE;
                    ld_ack_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= 8'd0;
                end

                S_FETCH: begin
                    // Read data lags the address by one cycle, so the byte
                    // arriving now belongs to the previous k.
                    case (k_q)
                        2'd1:    byte_buf_q[7:0]   <= MEM_RDATA;
                        2'd2:    byte_buf_q[15:8]  <= MEM_RDATA;
                        2'd3:    byte_buf_q[23:16] <= MEM_RDATA;
                        default: ;
                    endcase
                    if (k_q == 2'd3) begin
                        state_q    <= S_FWAIT;
                        mem_addr_q <= '0;
                    end else begin
                        k_q        <= k_q + 2'd1;
                        mem_addr_q <= mem_addr_q + ADDR_ONE;
                    end
                end

                S_FWAIT: begin
                    state_q    <= S_FDONE;
                    if_data_q  <= {MEM_RDATA, byte_buf_q};
                    if_fault_q <= 1'b0;
                    if_ack_q   <= 1'b1;
                end

                S_FDONE, S_FAULT: begin
                    state_q  <= S_IDLE;
                    if_ack_q <= 1'b0;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign CLR_BUSY  = clr_busy_q;
    assign LD_ACK    = ld_ack_q;
    assign IF_ACK    = if_ack_q;
    assign IF_DATA   = if_data_q;
    assign IF_FAULT  = if_fault_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter with a behavioural 1-cycle-latency byte RAM.
module tb_prog_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              CLR_REQ;
    logic              CLR_BUSY;
    logic              LD_REQ;
    logic [ADDR_W-1:0] LD_ADDR;
    logic [7:0]        LD_DATA;
    logic              LD_ACK;
    logic              IF_REQ;
    logic [31:0]       IF_ADDR;
    logic              IF_ACK;
    logic [31:0]       IF_DATA;
    logic              IF_FAULT;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_WE;
    logic [7:0]        MEM_WDATA;
    logic [7:0]        MEM_RDATA;

    logic [7:0] ram [DEPTH];

    prog_mem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY),
        .LD_REQ(LD_REQ), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_ACK(LD_ACK),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_DATA(IF_DATA),
        .IF_FAULT(IF_FAULT),
        .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
        MEM_RDATA <= ram[MEM_ADDR];
    end

    // Activity monitor, sampled on the falling edge.
    int we_cnt    = 0;
    int busy_cnt  = 0;
    int ifack_cnt = 0;
    int nz_cnt    = 0;
    int ack_log[$];

    always @(negedge CLK) begin
        if (MEM_WE)          we_cnt++;
        if (CLR_BUSY)        busy_cnt++;
        if (IF_ACK)          ifack_cnt++;
        if (MEM_ADDR != '0)  nz_cnt++;
        if (LD_ACK)          ack_log.push_back(1);
        if (IF_ACK)          ack_log.push_back(2);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; lat = cycles from grant cycle to ACK cycle.
    task automatic do_load(input logic [ADDR_W-1:0] a, input logic [7:0] d, output int lat);
        LD_ADDR = a;
        LD_DATA = d;
        LD_REQ  = 1'b1;
        lat = 0;
        @(negedge CLK);
        while (!LD_ACK && lat < 3000) begin
            lat++;
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        LD_REQ = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, output int lat,
                            output logic [31:0] data, output logic fault);
        IF_ADDR = a;
        IF_REQ  = 1'b1;
        lat = 0;
        @(negedge CLK);
        while (!IF_ACK && lat < 3000) begin
            lat++;
            @(negedge CLK);
        end
        data  = IF_DATA;
        fault = IF_FAULT;
        @(posedge CLK);
        #1;
        IF_REQ = 1'b0;
    endtask

    task automatic check_idle_outputs(input string pfx);
        check_val({pfx, "_clr_busy"}, 32'(CLR_BUSY), 32'd0);
        check_val({pfx, "_ld_ack"},   32'(LD_ACK),   32'd0);
        check_val({pfx, "_if_ack"},   32'(IF_ACK),   32'd0);
        check_val({pfx, "_if_data"},  IF_DATA,       32'd0);
        check_val({pfx, "_if_fault"}, 32'(IF_FAULT), 32'd0);
        check_val({pfx, "_mem_addr"}, 32'(MEM_ADDR), 32'd0);
        check_val({pfx, "_mem_we"},   32'(MEM_WE),   32'd0);
        check_val({pfx, "_mem_wdata"},32'(MEM_WDATA),32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          snap_we, snap_nz, snap_busy, snap_ack, idx, nzb, wait_n;
        logic [31:0] data;
        logic        fault;
        logic [31:0] bad_addr [4];

        RESET   = 1'b1;
        CLR_REQ = 1'b0;
        LD_REQ  = 1'b0;
        LD_ADDR = '0;
        LD_DATA = 8'd0;
        IF_REQ  = 1'b0;
        IF_ADDR = 32'd0;

        // 1: reset state, then idle
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_idle_outputs("reset");
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        snap_we = we_cnt;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check_idle_outputs("idle");
        check_val("idle_we_count", 32'(we_cnt - snap_we), 32'd0);
        @(posedge CLK);
        #1;

        // 2: single loader write, inspect the write cycle
        snap_we = we_cnt;
        LD_ADDR = 10'h005;
        LD_DATA = 8'hA5;
        LD_REQ  = 1'b1;
        @(negedge CLK);
        check_val("ld_c0_we", 32'(MEM_WE), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        check_val("ld_c1_we",    32'(MEM_WE),    32'd1);
        check_val("ld_c1_addr",  32'(MEM_ADDR),  32'h005);
        check_val("ld_c1_wdata", 32'(MEM_WDATA), 32'hA5);
        check_val("ld_c1_ack",   32'(LD_ACK),    32'd1);
        @(posedge CLK);
        #1;
        LD_REQ = 1'b0;
        @(negedge CLK);
        check_val("ld_c2_ack", 32'(LD_ACK), 32'd0);
        check_val("ld_c2_we",  32'(MEM_WE), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        check_val("ld_we_count", 32'(we_cnt - snap_we), 32'd1);
        check_val("ld_ram5",     32'(ram[5]),            32'hA5);

        // 3: aligned fetch
        do_load(10'd8,  8'h11, lat);
        check_val("ld8_lat", 32'(lat), 32'd1);
        do_load(10'd9,  8'h22, lat);
        do_load(10'd10, 8'h33, lat);
        do_load(10'd11, 8'h44, lat);
        snap_we = we_cnt;
        do_fetch(32'd8, lat, data, fault);
        check_val("f8_lat",   32'(lat),   32'd6);
        check_val("f8_data",  data,       32'h44332211);
        check_val("f8_fault", 32'(fault), 32'd0);
        check_val("f8_no_we", 32'(we_cnt - snap_we), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        check_val("f8_hold", IF_DATA, 32'h44332211);

        // top-of-memory word is legal
        do_load(10'h3FC, 8'h01, lat);
        do_load(10'h3FD, 8'h02, lat);
        do_load(10'h3FE, 8'h03, lat);
        do_load(10'h3FF, 8'h04, lat);
        do_fetch(32'd1020, lat, data, fault);
        check_val("f1020_lat",   32'(lat),   32'd6);
        check_val("f1020_data",  data,       32'h04030201);
        check_val("f1020_fault", 32'(fault), 32'd0);

        // 4: rejected fetches
        bad_addr[0] = 32'h0000_0006;
        bad_addr[1] = 32'hFFFF_FFFF;
        bad_addr[2] = 32'd1021;
        bad_addr[3] = 32'd1024;
        for (int i = 0; i < 4; i++) begin
            snap_we = we_cnt;
            snap_nz = nz_cnt;
            do_fetch(bad_addr[i], lat, data, fault);
            check_val($sformatf("fault%0d_lat", i),   32'(lat),   32'd1);
            check_val($sformatf("fault%0d_flag", i),  32'(fault), 32'd1);
            check_val($sformatf("fault%0d_data", i),  data,       32'd0);
            check_val($sformatf("fault%0d_noacc", i), 32'((we_cnt - snap_we) + (nz_cnt - snap_nz)), 32'd0);
        end

        // 5a: both requesters held -> L F L F L F
        idx = ack_log.size();
        fork
            begin
                int ll;
                for (int i = 0; i < 3; i++) begin
                    do_load(10'(256 + i), 8'(8'hC0 + i), ll);
                    check_val($sformatf("alt_ld%0d_done", i), 32'(ll < 3000), 32'd1);
                    @(posedge CLK);
                    #1;
                end
            end
            begin
                int          fl;
                logic [31:0] fd;
                logic        ff;
                for (int j = 0; j < 3; j++) begin
                    do_fetch(32'd8, fl, fd, ff);
                    check_val($sformatf("alt_f%0d_data", j), fd, 32'h44332211);
                    @(posedge CLK);
                    #1;
                end
            end
        join
        check_val("alt_count", 32'(ack_log.size() - idx), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("alt_order%0d", i),
                      (idx + i < ack_log.size()) ? 32'(ack_log[idx + i]) : 32'd0,
                      (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        check_val("alt_ram102", 32'(ram[10'h102]), 32'hC2);

        // 5b: tie right after a load goes to fetch
        do_load(10'h010, 8'h77, lat);
        idx = ack_log.size();
        fork
            begin
                int ll;
                do_load(10'h011, 8'h78, ll);
            end
            begin
                int          fl;
                logic [31:0] fd;
                logic        ff;
                do_fetch(32'd8, fl, fd, ff);
            end
        join
        check_val("tie_first",  (ack_log.size() > idx)     ? 32'(ack_log[idx])     : 32'd0, 32'd2);
        check_val("tie_second", (ack_log.size() > idx + 1) ? 32'(ack_log[idx + 1]) : 32'd0, 32'd1);

        // 5c: clear requested mid-fetch
        @(posedge CLK);
        #1;
        snap_busy = busy_cnt;
        snap_we   = we_cnt;
        wait_n    = 0;
        fork
            begin
                do_fetch(32'd8, lat, data, fault);
            end
            begin
                repeat (3) @(posedge CLK);
                #1;
                CLR_REQ = 1'b1;
                @(negedge CLK);
                while (!CLR_BUSY && wait_n < 3000) begin
                    wait_n++;
                    @(negedge CLK);
                end
                @(posedge CLK);
                #1;
                CLR_REQ = 1'b0;
            end
        join
        check_val("clr_fetch_lat",  32'(lat), 32'd6);
        check_val("clr_fetch_data", data,     32'h44332211);
        check_val("clr_start_wait", 32'(wait_n), 32'd5);
        repeat (DEPTH + 20) @(posedge CLK);
        #1;
        check_val("clr_busy_cycles", 32'(busy_cnt - snap_busy), 32'd1024);
        check_val("clr_we_cycles",   32'(we_cnt - snap_we),     32'd1024);
        nzb = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] != 8'd0) nzb++;
        check_val("clr_ram_nonzero", 32'(nzb), 32'd0);

        // 6: reset in fetch cycle 3
        do_load(10'd8, 8'h11, lat);
        do_fetch(32'd8, lat, data, fault);
        check_val("pre_rst_data", data, 32'h00000011);
        snap_ack = ifack_cnt;
        IF_ADDR = 32'd8;
        IF_REQ  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET  = 1'b0;
        IF_REQ = 1'b0;
        @(negedge CLK);
        check_val("rst_if_ack",   32'(IF_ACK),   32'd0);
        check_val("rst_if_data",  IF_DATA,       32'd0);
        check_val("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check_val("rst_mem_we",   32'(MEM_WE),   32'd0);
        repeat (10) @(posedge CLK);
        #1;
        check_val("rst_no_ack", 32'(ifack_cnt - snap_ack), 32'd0);

        // first tie after reset goes to the loader; fetch then sees the new byte
        idx = ack_log.size();
        fork
            begin
                int ll;
                do_load(10'h201, 8'h5A, ll);
            end
            begin
                int          fl;
                logic        ff;
                do_fetch(32'h200, fl, data, ff);
                check_val("post_rst_fault", 32'(ff), 32'd0);
            end
        join
        check_val("post_rst_first", (ack_log.size() > idx) ? 32'(ack_log[idx]) : 32'd0, 32'd1);
        check_val("post_rst_data",  data, 32'h00005A00);

        repeat (3) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
